// File: rtl/demod_pkg.sv
// Shared constants, FSM states and the fixed-point dequantise helper for the FM demodulator.
package demod_pkg;

    localparam int unsigned QUANT_BITS_DEF = 10;
    localparam int          GAIN_DEF       = 758;   // 0.7407 at Q10
    localparam int          QUAD1          = 804;   // pi/4 at Q10
    localparam int          QUAD3          = 2413;  // 3*pi/4 at Q10
    localparam int unsigned DQ_W           = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV_INIT,
        DIV,
        ANGLE,
        WRITE
    } state_t;

    // Arithmetic right shift: floors toward minus infinity.
    function automatic logic signed [DQ_W-1:0] dq(input logic signed [DQ_W-1:0] v,
                                                  input int unsigned shift);
        return v >>> shift;
    endfunction

endpackage

// File: rtl/fm_demod_stage_if.sv
// Sample-in / result-out FIFO bus of the FM demodulator stage.
interface fm_demod_stage_if #(
    parameter int unsigned DATA_SIZE = 16
);
    logic [2*DATA_SIZE-1:0] iq_in;
    logic                   iq_wr_en;
    logic                   iq_full;
    logic [DATA_SIZE-1:0]   data_out;
    logic                   data_out_rd_en;
    logic                   data_out_empty;

    modport master (
        output iq_in, iq_wr_en, data_out_rd_en,
        input  iq_full, data_out, data_out_empty
    );

    modport slave (
        input  iq_in, iq_wr_en, data_out_rd_en,
        output iq_full, data_out, data_out_empty
    );
endinterface

// File: rtl/div_serial.sv
// Signed restoring divider, one quotient bit per cycle, quotient truncated toward zero.
module div_serial #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic signed [WIDTH-1:0] quotient,
    output logic                    done
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic             neg;
    logic [WIDTH-1:0] dvs, rem, quo, rem_nxt, quo_nxt;
    logic [WIDTH:0]   rem_sh, diff;

    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs};
        if (diff[WIDTH]) begin
            rem_nxt = rem_sh[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end
    end

    // done flags the final iteration; quotient is valid from the following cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            done     <= 1'b0;
            neg      <= 1'b0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                cnt  <= CW'(WIDTH);
                done <= (WIDTH == 1);
                neg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                quo  <= dividend[WIDTH-1] ? -dividend : dividend;
                dvs  <= divisor[WIDTH-1] ? -divisor : divisor;
                rem  <= '0;
            end else if (cnt != '0) begin
                rem  <= rem_nxt;
                quo  <= quo_nxt;
                cnt  <= cnt - 1'b1;
                done <= (cnt == CW'(2));
                if (cnt == CW'(1)) quotient <= neg ? -quo_nxt : quo_nxt;
            end
        end
    end

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO; SHOW_AHEAD presents the head directly, otherwise dout registers on each pop.
module fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 16,
    parameter bit          SHOW_AHEAD = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic             do_wr, do_rd;

    // A write while full is dropped, so a pop on a full FIFO wins over a concurrent write.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        count_nxt = count;
        if (do_wr && !do_rd)      count_nxt = count + 1'b1;
        else if (do_rd && !do_wr) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    generate
        if (SHOW_AHEAD) begin : g_show_ahead
            assign dout = empty ? '0 : mem[rd_ptr];
        end else begin : g_registered
            always_ff @(posedge clock) begin
                if (reset)      dout <= '0;
                else if (do_rd) dout <= mem[rd_ptr];
            end
        end
    endgenerate

endmodule

// File: rtl/fm_demod_stage.sv
// FM polar discriminator: conjugate product with the previous sample, quantised arctangent, gain.
module fm_demod_stage
    import demod_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 16,
    parameter int unsigned QUANT_BITS = QUANT_BITS_DEF,
    parameter int          GAIN       = GAIN_DEF,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    fm_demod_stage_if.slave     bus,
    input  logic                flush,
    output logic [31:0]         sample_count,
    output logic                busy
);
    localparam int unsigned W = 2 * DATA_SIZE;

    state_t                 state;
    logic [W-1:0]           in_dout;
    logic                   in_empty, in_rd_en_c, out_full, out_wr_en_c, div_start_c, div_done;
    logic signed [W-1:0]    cur_r, cur_i, prev_r, prev_i, r_reg, i_reg;
    logic signed [W-1:0]    abs_y, num_c, den_c, quot, angle_c;
    logic                   x_neg, y_neg;
    logic [DATA_SIZE-1:0]   out_val;

    function automatic logic signed [W-1:0] dqw(input logic signed [W-1:0] v);
        return W'(dq(DQ_W'(v), QUANT_BITS));
    endfunction

    fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH), .SHOW_AHEAD(1'b0)) u_in_fifo (
        .clock (clock),          .reset (reset),
        .wr_en (bus.iq_wr_en),   .din   (bus.iq_in),
        .rd_en (in_rd_en_c),     .dout  (in_dout),
        .full  (bus.iq_full),    .empty (in_empty)
    );

    fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH), .SHOW_AHEAD(1'b1)) u_out_fifo (
        .clock (clock),               .reset (reset),
        .wr_en (out_wr_en_c),         .din   (out_val),
        .rd_en (bus.data_out_rd_en),  .dout  (bus.data_out),
        .full  (out_full),            .empty (bus.data_out_empty)
    );

    div_serial #(.WIDTH(W)) u_div (
        .clock    (clock),  .reset   (reset),
        .start    (div_start_c),
        .dividend (num_c),  .divisor (den_c),
        .quotient (quot),   .done    (div_done)
    );

    assign cur_r = {{DATA_SIZE{in_dout[W-1]}}, in_dout[W-1 -: DATA_SIZE]};
    assign cur_i = {{DATA_SIZE{in_dout[DATA_SIZE-1]}}, in_dout[DATA_SIZE-1:0]};

    // Flush suppresses both the pop and the result write so nothing is lost or half-committed.
    assign in_rd_en_c  = (state == IDLE) && !in_empty && !flush;
    assign out_wr_en_c = (state == WRITE) && !out_full && !flush;
    assign div_start_c = (state == DIV_INIT);

    // Arctangent operands; den is at least 1 by construction.
    always_comb begin
        abs_y = (i_reg[W-1] ? -i_reg : i_reg) + W'(1);
        if (r_reg[W-1]) begin
            num_c = (r_reg + abs_y) <<< QUANT_BITS;
            den_c = abs_y - r_reg;
        end else begin
            num_c = (r_reg - abs_y) <<< QUANT_BITS;
            den_c = r_reg + abs_y;
        end
    end

    always_comb begin
        angle_c = (x_neg ? W'(QUAD3) : W'(QUAD1)) - dqw(W'(QUAD1) * quot);
        if (y_neg) angle_c = -angle_c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            prev_r       <= '0;
            prev_i       <= '0;
            r_reg        <= '0;
            i_reg        <= '0;
            x_neg        <= 1'b0;
            y_neg        <= 1'b0;
            out_val      <= '0;
            sample_count <= '0;
        end else if (flush) begin
            state  <= IDLE;
            busy   <= 1'b0;
            prev_r <= '0;
            prev_i <= '0;
        end else begin
            unique case (state)
                IDLE: if (!in_empty) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: begin
                    r_reg  <= dqw(prev_r * cur_r) + dqw(prev_i * cur_i);
                    i_reg  <= dqw(prev_r * cur_i) - dqw(prev_i * cur_r);
                    prev_r <= cur_r;
                    prev_i <= cur_i;
                    state  <= DIV_INIT;
                end
                DIV_INIT: begin
                    x_neg <= r_reg[W-1];
                    y_neg <= i_reg[W-1];
                    state <= DIV;
                end
                DIV: if (div_done) state <= ANGLE;
                ANGLE: begin
                    out_val <= DATA_SIZE'(dqw(W'(GAIN) * angle_c));
                    state   <= WRITE;
                end
                WRITE: if (!out_full) begin
                    sample_count <= sample_count + 32'd1;
                    state        <= IDLE;
                    busy         <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fm_demod_stage.md
# fm_demod_stage

- Parametrised, self-contained FM demodulator stage.
- Accepts paired I/Q samples through one input FIFO and computes the polar discriminator (conjugate product, then a quantised arctangent using a serial divider).
- Scales the result by the demodulation gain and delivers it through an output FIFO.
- Sits between the channel filter and the audio low-pass/decimation stages.
- Adds three things over the previous demod top: a joint I/Q write, configurable depth/precision/gain, and flush and status outputs.

## Interface
- DATA_SIZE, 16: sample width; signed, fixed point with QUANT_BITS fraction bits.
- QUANT_BITS, 10: fraction bits used by every dequantise step.
- GAIN, 758: demodulation gain, quantised (0.7407 × 2^10).
- FIFO_DEPTH, 16: depth of the input FIFO and of the output FIFO.
- clock, in, 1: single clock domain.
- reset, in, 1: synchronous, active-high.
- iq_in, in, 2*DATA_SIZE: {real, imag}, with real in the upper half.
- iq_wr_en, in, 1: pushes iq_in into the input FIFO.
- iq_full, out, 1: input FIFO is full.
- data_out, out, DATA_SIZE: head of the output FIFO.
- data_out_rd_en, in, 1: pops the output FIFO.
- data_out_empty, out, 1: output FIFO is empty.
- flush, in, 1: clears the previous-sample state and aborts the sample in flight.
- sample_count, out, 32: number of samples written to the output FIFO.
- busy, out, 1: FSM is not in IDLE.

## Operation
- **Dequantise:** DQ(v) = v >>> QUANT_BITS (arithmetic shift). All intermediates are 2*DATA_SIZE signed.
- **State:** prev_r and prev_i both reset to 0.
- **Conjugate product:**
  - r = DQ(prev_r*cur_r) + DQ(prev_i*cur_i)
  - i = DQ(prev_r*cur_i) − DQ(prev_i*cur_r)
  - prev_r/prev_i take cur_r/cur_i in the same cycle.
- **Arctangent qarctan(y=i, x=r):** constants QUAD1 = 804 and QUAD3 = 2413 (π/4 and 3π/4 at Q10).
  - abs_y = |y| + 1.
  - If x ≥ 0: num = (x − abs_y) << QUANT_BITS, den = x + abs_y, angle = QUAD1 − DQ(QUAD1*q).
  - Otherwise: num = (x + abs_y) << QUANT_BITS, den = abs_y − x, angle = QUAD3 − DQ(QUAD1*q).
  - q = num/den, truncated toward zero. den ≥ 1 always, so there is no divide-by-zero path.
  - If y < 0: angle = −angle.
- **Output:** out = DQ(GAIN*angle), truncated to DATA_SIZE.
- **FSM states and transitions:**
  - IDLE: if the input FIFO is non-empty, assert the input rd_en for one cycle and go to LOAD.
  - LOAD: capture the FIFO dout, register r and i, go to DIV_INIT.
  - DIV_INIT: form num, den and the signs, start the divider.
  - DIV: 2*DATA_SIZE iterations.
  - ANGLE: compute angle.
  - WRITE: if the output FIFO is not full, assert its wr_en with out, increment sample_count, go to IDLE. Otherwise hold.
- **flush:** in any state it returns the FSM to IDLE next cycle. It zeroes prev and discards the in-flight sample (no output write). FIFO contents are kept. If flush and reset are asserted together, reset wins.
- **sample_count:** wraps modulo 2^32.

## Timing
- **Reset values:** iq_full 0, data_out_empty 1, data_out 0, busy 0, sample_count 0, prev 0, FSM IDLE. The FIFOs are emptied.
- **Latency:**
  - Input rd_en at cycle 0; FIFO dout is valid at cycle 1 (LOAD).
  - DIV_INIT at cycle 2; DIV occupies cycles 3–34 (DATA_SIZE=16); ANGLE at cycle 35.
  - Output wr_en at cycle 36 if the output FIFO is not full.
  - Throughput is one sample per 37 cycles; the next pop can occur at cycle 37.
- **Input FIFO:**
  - A write while iq_full is high is ignored.
  - On a simultaneous write and pop when full, the pop happens and the write is ignored.
- **Output backpressure:** WRITE holds with data stable. No input pop happens while in WRITE.
- **Status timing:** busy is high from LOAD through WRITE; it is low in the cycle the pop is issued.

## Structure
- **Package demod_pkg:**
  - QUAD1/QUAD3 derivation constants.
  - Default QUANT_BITS and GAIN.
  - The state enum: IDLE, LOAD, DIV_INIT, DIV, ANGLE, WRITE.
  - A dequantise function.
- **Sub-module div_serial:** signed restoring divider.
  - Parameter: WIDTH.
  - Handshake: start/done.
  - Quotient truncates toward zero.
  - Latency: WIDTH cycles.
- **FIFOs:** two instances of the existing fifo, with widths 2*DATA_SIZE and DATA_SIZE.

## Test plan
- After reset, write {0x0400, 0x0000} and wait for data_out_empty to fall.
  - Expect data_out = 1190 and sample_count = 1.
  - Expect the output write 36 cycles after the pop.
- Write {0x0400, 0x0000} twice.
  - First output is 1190.
  - Second output is 1: r = 1024, i = 0, q = 1022, angle = 2.
- After {0x0400, 0x0000}, write {0x0000, 0x0400} and, separately after reset, {0x0000, 0xFC00}.
  - Second outputs are 1190 and −1191 (0xFB59) respectively; this checks the arithmetic-shift floor.
- Fill the output FIFO (16 samples) without reading.
  - The FSM holds in WRITE, busy stays 1, no further pops occur, and iq_full rises after 16 more writes.
  - After one data_out_rd_en, exactly one write proceeds.
- Sequence: write {0x0400, 0}, wait for output, write {0x0400, 0}, pulse flush during DIV, then write {0x0400, 0}.
  - The aborted sample produces no output.
  - The next output is 1190 (prev cleared), and sample_count increments only for completed samples.
- Assert reset mid-DIV with both FIFOs non-empty.
  - All outputs return to their reset values next cycle, and no write occurs.
